// File: rtl/grf_scoreboard.sv
// GRF write scoreboard: per-register pending-write counters and decode stall.
// Optional macro SB_WB_BYPASS_EN lets a same-cycle retire clear the hazard.
module grf_scoreboard #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic        issue_we,
  input  logic [4:0]  issue_wa,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic        rs_used,
  input  logic        rt_used,
  input  logic        wb_valid,
  input  logic [4:0]  wb_wa,
  input  logic        flush,
  output logic        stall,
  output logic        issue_accept,
  output logic [31:0] busy_mask,
  output logic [4:0]  inflight,
  output logic        err
);

  localparam logic [CNT_W-1:0] LP_MAX  = '1;
  localparam logic [4:0]       LP_MAXI = 5'(MAX_INFLIGHT);

  logic [CNT_W-1:0] r_cnt [32];
  logic [4:0]       r_infl;
  logic             r_err;

  logic [CNT_W-1:0] w_cnt_nxt [32];
  logic [4:0]       w_infl_nxt;
  logic             w_err_nxt;
  logic             w_ret;
  logic             w_bad;
  logic             w_iss;
  logic             w_stall;
  logic [CNT_W-1:0] w_rs_cnt;
  logic [CNT_W-1:0] w_rt_cnt;
  logic [CNT_W-1:0] w_wa_cnt;
  logic [4:0]       w_infl_eff;

  // Classify this cycle's WB write as a good retire or a bad one.
  always_comb begin
    w_ret = wb_valid && (wb_wa != 5'd0) && (r_cnt[wb_wa] != '0);
    w_bad = wb_valid && (wb_wa != 5'd0) && (r_cnt[wb_wa] == '0);
  end

  // Counts seen by the hazard terms, optionally net of a same-cycle retire.
  always_comb begin
    w_rs_cnt   = r_cnt[rs];
    w_rt_cnt   = r_cnt[rt];
    w_wa_cnt   = r_cnt[issue_wa];
    w_infl_eff = r_infl;
`ifdef SB_WB_BYPASS_EN
    if (w_ret) begin
      if (wb_wa == rs)       w_rs_cnt = r_cnt[rs] - CNT_W'(1);
      if (wb_wa == rt)       w_rt_cnt = r_cnt[rt] - CNT_W'(1);
      if (wb_wa == issue_wa) w_wa_cnt = r_cnt[issue_wa] - CNT_W'(1);
      w_infl_eff = r_infl - 5'd1;
    end
`endif
  end

  // Stall on RAW, per-register saturation or total in-flight limit.
  always_comb begin
    w_stall = 1'b0;
    if (issue_valid) begin
      if (rs_used && rs != 5'd0 && w_rs_cnt != '0)
        w_stall = 1'b1;
      if (rt_used && rt != 5'd0 && w_rt_cnt != '0)
        w_stall = 1'b1;
      if (issue_we && issue_wa != 5'd0 && w_wa_cnt == LP_MAX)
        w_stall = 1'b1;
      if (issue_we && issue_wa != 5'd0 && w_infl_eff == LP_MAXI)
        w_stall = 1'b1;
    end
    w_iss = issue_valid && !w_stall && issue_we && (issue_wa != 5'd0);
  end

  // Next-state counters: issue increments, retire decrements, flush clears.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (i != 0) begin
        if (w_iss && issue_wa == 5'(i))
          w_cnt_nxt[i] = w_cnt_nxt[i] + CNT_W'(1);
        if (w_ret && wb_wa == 5'(i))
          w_cnt_nxt[i] = w_cnt_nxt[i] - CNT_W'(1);
      end
    end
    w_infl_nxt = r_infl + {4'd0, w_iss} - {4'd0, w_ret};
    w_err_nxt  = r_err | w_bad;
    if (flush) begin
      for (int i = 0; i < 32; i++) w_cnt_nxt[i] = '0;
      w_infl_nxt = 5'd0;
      w_err_nxt  = r_err;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= '0;
      r_infl <= 5'd0;
      r_err  <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) r_cnt[i] <= w_cnt_nxt[i];
      r_infl <= w_infl_nxt;
      r_err  <= w_err_nxt;
    end
  end

  // Registered-state views.
  always_comb begin
    for (int i = 0; i < 32; i++)
      busy_mask[i] = (i != 0) && (r_cnt[i] != '0);
  end

  assign stall        = w_stall;
  assign issue_accept = issue_valid & ~w_stall;
  assign inflight     = r_infl;
  assign err          = r_err;

endmodule

// File: doc/grf_scoreboard.md
Name: grf_scoreboard

Overview:
- Register-file hazard scheduler for the pipelined MIPS core.
- Tracks outstanding writes to each GRF register, issued at decode and retired when the writeback stage writes the GRF.
- Issues a stall to the decode stage on RAW hazards, same-register write-counter saturation, or total in-flight overflow.
- Sits beside the GRF; the pipeline WB stage drives its retire port with the same address and enable it drives to the GRF write port.

Parameters:
- CNT_W, 2: width of each per-register pending-write counter; per-register max is 2^CNT_W-1.
- MAX_INFLIGHT, 4: maximum total outstanding tracked writes, 1..31.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- issue_valid  input  1  decode stage presents an instruction this cycle.
- issue_we  input  1  instruction will write the GRF.
- issue_wa  input  5  destination register of the issued instruction.
- rs  input  5  source register 1.
- rt  input  5  source register 2.
- rs_used  input  1  instruction reads rs.
- rt_used  input  1  instruction reads rt.
- wb_valid  input  1  WB stage writes the GRF this cycle (RegWrite).
- wb_wa  input  5  WB destination register.
- flush  input  1  synchronous pipeline flush; discards all tracking.
- stall  output  1  decode must hold; the instruction is not accepted.
- issue_accept  output  1  equal to issue_valid & ~stall.
- busy_mask  output  32  bit i set when counter i is nonzero; bit 0 is always 0.
- inflight  output  5  total outstanding tracked writes.
- err  output  1  sticky; set on a retire to a register whose counter is 0.

Behaviour:
- State: 31 counters cnt[1..31], each CNT_W bits; inflight counter; err flag. Register $0 is never tracked: issue_wa=0 and wb_wa=0 are ignored.
- Reset (asynchronous): all counters 0, inflight=0, err=0. Therefore stall=0 (combinationally), busy_mask=0, issue_accept=issue_valid.
- stall is combinational from registered state and current inputs. stall = issue_valid & (any of the following):
  - rs_used & rs!=0 & cnt[rs]!=0
  - rt_used & rt!=0 & cnt[rt]!=0
  - issue_we & issue_wa!=0 & cnt[issue_wa]==max
  - issue_we & issue_wa!=0 & inflight==MAX_INFLIGHT
- stall is 0 whenever issue_valid=0.
- A retire in the same cycle does not clear a hazard unless SB_WB_BYPASS_EN is defined.
- Issue effect: when issue_accept & issue_we & issue_wa!=0, then next cycle cnt[issue_wa]+=1 and inflight+=1.
- Retire effect: when wb_valid & wb_wa!=0 & cnt[wb_wa]!=0, then next cycle cnt[wb_wa]-=1 and inflight-=1.
- Bad retire: wb_valid & wb_wa!=0 & cnt[wb_wa]==0 sets err (sticky until reset). No counter changes and no underflow.
- Simultaneous issue and retire:
  - Same register: cnt is unchanged and inflight is unchanged.
  - Different registers: both updates apply; inflight is unchanged.
- No wrap-around: increments are blocked by the saturation stall terms; decrements are blocked at 0.
- flush has highest priority. Next cycle all counters=0 and inflight=0; that cycle's issue and retire are discarded; err is kept.
- stall in a flush cycle is still computed normally; the core ignores it.
- Latency: state updates are visible one cycle after the causing edge. busy_mask and inflight are registered-state views with no combinational path from inputs.
- Reset asserted mid-operation clears everything immediately, regardless of clk.

Optional Feature:
- Macro: SB_WB_BYPASS_EN.
- Defined: the RAW terms use the effective count. Effective count = cnt[r] minus 1 when wb_valid & wb_wa==r & cnt[r]!=0. A retire in the same cycle therefore releases the dependent instruction with no bubble. The saturation terms use the effective count and the effective inflight in the same way.
- Not defined: only registered state is used, so the dependent instruction incurs one extra stall cycle after retire.

Test Plan:
- Reset, then issue_valid=1, issue_we=1, issue_wa=8 -> stall=0. Next cycle busy_mask=0x00000100, inflight=1.
- cnt[8]=1; issue with rs=8, rs_used=1 -> stall=1.
  - wb_valid=1, wb_wa=8 in the same cycle: bypass off -> stall=1 that cycle and 0 next cycle; bypass on -> stall=0 that cycle.
- Issue writes to regs 1, 2, 3, 4 (MAX_INFLIGHT=4) -> inflight=4. A fifth write to reg 5 -> stall=1. A non-writing issue with no hazard -> stall=0.
- Three accepted writes to reg 9 (CNT_W=2) -> cnt=3. A fourth write to reg 9 -> stall=1. Simultaneous issue and retire on reg 9 with cnt=2 -> cnt stays 2.
- wb_valid=1, wb_wa=12 with cnt[12]=0 -> err=1 and counters unchanged. flush -> busy_mask=0 and inflight=0, err still 1. reset -> err=0.
- Issue_wa=0 and wb_wa=0 in any combination -> no state change, stall=0 from those terms.
